mix_columns_seq: RTL

MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

---
 rtl/mix_columns_seq_pkg.sv | 34 +++
 rtl/gf_xtime.sv | 44 ++++
 rtl/mix_columns_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mix_columns_seq_pkg.sv
// Shared AES package for the sequential MixColumns block.
// Holds the FSM state type, the GF(2^8) reduction constant, the byte/column
// index helpers used to address the 128-bit state, and the xtime function.
package mix_columns_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Low byte of x^8 + x^4 + x^3 + x + 1.
    localparam logic [7:0] XT_POLY = 8'h1B;

    // Byte index of row i within column c.
    function automatic logic [3:0] col_byte(input logic [1:0] c, input logic [1:0] i);
        return {c, i};
    endfunction

    // LSB position of byte k; byte 0 sits in the most significant bits.
    function automatic int unsigned byte_lsb(input logic [3:0] k);
        return 32'd8 * (32'd15 - {28'd0, k});
    endfunction

    // LSB position of column c.
    function automatic int unsigned col_lsb(input logic [1:0] c);
        return 32'd32 * (32'd3 - {30'd0, c});
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? XT_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/gf_xtime.sv
// Pipelined GF(2^8) multiply-by-x with a valid bit travelling alongside.
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   i_valid     : i_byte is a request this cycle
//   i_byte      : operand
//   o_valid     : o_byte holds a result (LAT cycles after the request)
//   o_byte      : xtime(i_byte)
module gf_xtime
    import mix_columns_seq_pkg::*;
#(
    parameter int unsigned LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    input  logic [7:0] i_byte,
    output logic       o_valid,
    output logic [7:0] o_byte
);

    logic [7:0]     r_data  [LAT];
    logic [LAT-1:0] r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int s = 0; s < int'(LAT); s++) begin
                r_data[s] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_data[0]  <= xtime(i_byte);
            // Extra stages only delay the already-computed result.
            for (int s = 1; s < int'(LAT); s++) begin
                r_valid[s] <= r_valid[s-1];
                r_data[s]  <= r_data[s-1];
            end
        end
    end

    assign o_valid = r_valid[LAT-1];
    assign o_byte  = r_data[LAT-1];

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES forward MixColumns using one shared xtime unit.
// One byte is issued to gf_xtime per RUN cycle; results are captured in order,
// and each column is folded into out_state once its four xt values are held.
// Ports:
//   clk, rst               : clock and synchronous active-high reset
//   in_valid/in_ready      : input handshake, in_state latched on accept
//   in_state               : 128-bit state, byte 0 in bits [127:120]
//   out_valid/out_ready    : output handshake, out_state held in DONE
//   out_state              : MixColumns result, same byte order
//   busy                   : high whenever the FSM is not IDLE
module mix_columns_seq
    import mix_columns_seq_pkg::*;
#(
    parameter int unsigned XT_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    state_e       r_state;
    logic [127:0] r_in;
    logic [127:0] r_xt;
    logic [127:0] r_out;
    logic [3:0]   r_issue_cnt;
    logic         r_issue_done;
    logic [3:0]   r_cap_cnt;
    logic         r_asm;
    logic [1:0]   r_asm_col;
    logic         r_asm_last;
    logic         r_out_valid;

    logic         w_issue;
    logic [7:0]   w_issue_byte;
    logic         w_xt_valid;
    logic [7:0]   w_xt_byte;
    logic         w_cap;
    logic [7:0]   w_a   [4];
    logic [7:0]   w_x   [4];
    logic [7:0]   w_col [4];
    logic [31:0]  w_mix_col;

    assign w_issue      = (r_state == RUN) && !r_issue_done;
    assign w_issue_byte = r_in[byte_lsb(r_issue_cnt) +: 8];
    assign w_cap        = (r_state == RUN) && w_xt_valid;

    gf_xtime #(
        .LAT (XT_LAT)
    ) u_xtime (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_issue),
        .i_byte  (w_issue_byte),
        .o_valid (w_xt_valid),
        .o_byte  (w_xt_byte)
    );

    // r_i = xt(a_i) ^ xt(a_i+1) ^ a_i+1 ^ a_i+2 ^ a_i+3 for the column being assembled.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_a[i] = r_in[byte_lsb(col_byte(r_asm_col, 2'(i))) +: 8];
            w_x[i] = r_xt[byte_lsb(col_byte(r_asm_col, 2'(i))) +: 8];
        end
        for (int i = 0; i < 4; i++) begin
            w_col[i] = w_x[i] ^ w_x[(i+1)%4] ^ w_a[(i+1)%4] ^ w_a[(i+2)%4] ^ w_a[(i+3)%4];
        end
        w_mix_col = {w_col[0], w_col[1], w_col[2], w_col[3]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_in         <= '0;
            r_xt         <= '0;
            r_out        <= '0;
            r_issue_cnt  <= '0;
            r_issue_done <= 1'b0;
            r_cap_cnt    <= '0;
            r_asm        <= 1'b0;
            r_asm_col    <= '0;
            r_asm_last   <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_in         <= in_state;
                        r_issue_cnt  <= '0;
                        r_issue_done <= 1'b0;
                        r_cap_cnt    <= '0;
                        r_asm        <= 1'b0;
                        r_asm_last   <= 1'b0;
                        r_state      <= RUN;
                    end
                end
                RUN: begin
                    if (w_issue) begin
                        r_issue_cnt <= r_issue_cnt + 4'd1;
                        if (r_issue_cnt == 4'd15) begin
                            r_issue_done <= 1'b1;
                        end
                    end
                    // A column is ready the cycle after its fourth xt value lands.
                    r_asm      <= w_cap && (r_cap_cnt[1:0] == 2'd3);
                    r_asm_last <= w_cap && (r_cap_cnt == 4'd15);
                    if (w_cap) begin
                        r_xt[byte_lsb(r_cap_cnt) +: 8] <= w_xt_byte;
                        r_cap_cnt                      <= r_cap_cnt + 4'd1;
                        r_asm_col                      <= r_cap_cnt[3:2];
                    end
                    if (r_asm) begin
                        r_out[col_lsb(r_asm_col) +: 32] <= w_mix_col;
                    end
                    if (r_asm_last) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign out_state = r_out;

endmodule
